// File: rtl/arm_arb.sv
// rtl/arm_arb.sv - two-requester round-robin arbiter onto a single shared target port
//
// Purpose:
//   Grants one of two requesters (m0, m1) access to a shared target through a
//   three-state FSM (IDLE -> BUSY -> DONE). The granted request is registered onto
//   the arm_* port and held stable until the target acks or a timeout aborts it.
//   Completion is returned as a one-cycle m*_ack pulse with read data and error.
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   m0_* / m1_*  req,addr,wdata,wstrb,wr  requester inputs (req held until ack)
//   m0_* / m1_*  ack,rdata,err        one-cycle completion outputs
//   arm_req,arm_addr,arm_wdata,arm_wstrb,arm_wr  registered request to target
//   arm_ack,arm_err,arm_rdata         target completion inputs
//
// Parameter:
//   TIMEOUT  BUSY cycles without arm_ack before the transfer is aborted (1..65535)

module arm_arb #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    input  logic        m0_wr,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    input  logic        m1_wr,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic        arm_req,
    output logic [31:0] arm_addr,
    output logic [31:0] arm_wdata,
    output logic [3:0]  arm_wstrb,
    output logic        arm_wr,
    input  logic        arm_ack,
    input  logic        arm_err,
    input  logic [31:0] arm_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_CNT = TIMEOUT[15:0];

    state_t      state;
    logic        gnt_m1;      // requester owning the in-flight transfer
    logic        last_m1;     // most recently granted requester
    logic [15:0] tmo_cnt;
    logic [15:0] tmo_inc;
    logic        sel_m1;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_data;

    assign tmo_inc = tmo_cnt + 16'd1;

    // m1 wins when it is the only requester, or when both request and m0 was
    // granted last. Reset leaves last_m1=1 so m0 wins the first tie.
    always_comb begin
        sel_m1 = m1_req && (!m0_req || !last_m1);
    end

    // Target response takes precedence over a timeout landing on the same edge.
    always_comb begin
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_data  = 32'd0;
        if (state == BUSY) begin
            if (arm_ack) begin
                resp_valid = 1'b1;
                resp_err   = arm_err;
                resp_data  = arm_rdata;
            end else if (tmo_inc == TIMEOUT_CNT) begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                resp_data  = 32'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            gnt_m1    <= 1'b0;
            last_m1   <= 1'b1;
            tmo_cnt   <= 16'd0;
            arm_req   <= 1'b0;
            arm_addr  <= 32'd0;
            arm_wdata <= 32'd0;
            arm_wstrb <= 4'd0;
            arm_wr    <= 1'b0;
            m0_ack    <= 1'b0;
            m0_rdata  <= 32'd0;
            m0_err    <= 1'b0;
            m1_ack    <= 1'b0;
            m1_rdata  <= 32'd0;
            m1_err    <= 1'b0;
        end else begin
            // Completion outputs are single-cycle; they fall back to zero unless
            // the BUSY branch below produces a response on this edge.
            m0_ack   <= 1'b0;
            m0_rdata <= 32'd0;
            m0_err   <= 1'b0;
            m1_ack   <= 1'b0;
            m1_rdata <= 32'd0;
            m1_err   <= 1'b0;

            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        gnt_m1    <= sel_m1;
                        last_m1   <= sel_m1;
                        arm_addr  <= sel_m1 ? m1_addr  : m0_addr;
                        arm_wdata <= sel_m1 ? m1_wdata : m0_wdata;
                        arm_wstrb <= sel_m1 ? m1_wstrb : m0_wstrb;
                        arm_wr    <= sel_m1 ? m1_wr    : m0_wr;
                        arm_req   <= 1'b1;
                        tmo_cnt   <= 16'd0;
                        state     <= BUSY;
                    end
                end

                BUSY: begin
                    if (resp_valid) begin
                        arm_req <= 1'b0;
                        state   <= DONE;
                        if (gnt_m1) begin
                            m1_ack   <= 1'b1;
                            m1_rdata <= resp_data;
                            m1_err   <= resp_err;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_rdata <= resp_data;
                            m0_err   <= resp_err;
                        end
                    end else begin
                        tmo_cnt <= tmo_inc;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state   <= IDLE;
                    arm_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arm_arb.sv
// tb/tb_arm_arb.sv - self-checking bench for arm_arb

module tb_arm_arb;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk;
    logic        resetn;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_wr, m1_wr;
    logic        arm_ack, arm_err;
    logic [31:0] arm_rdata;

    // index 0: TIMEOUT=8, index 1: TIMEOUT=4; both share every input
    logic        m0a [2];
    logic        m1a [2];
    logic [31:0] m0r [2];
    logic [31:0] m1r [2];
    logic        m0e [2];
    logic        m1e [2];
    logic        areq [2];
    logic [31:0] aaddr [2];
    logic [31:0] awdata [2];
    logic [3:0]  awstrb [2];
    logic        awr [2];

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        arm_arb #(.TIMEOUT(g == 0 ? 8 : 4)) dut (
            .clk       (clk),
            .resetn    (resetn),
            .m0_req    (m0_req),
            .m0_addr   (m0_addr),
            .m0_wdata  (m0_wdata),
            .m0_wstrb  (m0_wstrb),
            .m0_wr     (m0_wr),
            .m0_ack    (m0a[g]),
            .m0_rdata  (m0r[g]),
            .m0_err    (m0e[g]),
            .m1_req    (m1_req),
            .m1_addr   (m1_addr),
            .m1_wdata  (m1_wdata),
            .m1_wstrb  (m1_wstrb),
            .m1_wr     (m1_wr),
            .m1_ack    (m1a[g]),
            .m1_rdata  (m1r[g]),
            .m1_err    (m1e[g]),
            .arm_req   (areq[g]),
            .arm_addr  (aaddr[g]),
            .arm_wdata (awdata[g]),
            .arm_wstrb (awstrb[g]),
            .arm_wr    (awr[g]),
            .arm_ack   (arm_ack),
            .arm_err   (arm_err),
            .arm_rdata (arm_rdata)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        m0, m1, ack, err;
        logic [31:0] rd;
        logic        e_req, e_a0, e_a1, e_e0, e_e1;
        logic [31:0] e_r0, e_r1, e_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic m0, input logic m1, input logic ack, input logic err,
                       input logic [31:0] rd, input logic e_req, input logic e_a0,
                       input logic e_a1, input logic e_e0, input logic e_e1,
                       input logic [31:0] e_r0, input logic [31:0] e_r1,
                       input logic [31:0] e_addr);
        vec_t v;
        v.m0 = m0; v.m1 = m1; v.ack = ack; v.err = err; v.rd = rd;
        v.e_req = e_req; v.e_a0 = e_a0; v.e_a1 = e_a1; v.e_e0 = e_e0; v.e_e1 = e_e1;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_addr = e_addr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic any_out(input int i);
        return areq[i] | awr[i] | (|aaddr[i]) | (|awdata[i]) | (|awstrb[i]) |
               m0a[i] | m1a[i] | m0e[i] | m1e[i] | (|m0r[i]) | (|m1r[i]);
    endfunction

    task automatic do_reset();
        resetn    = 1'b0;
        m0_req    = 1'b0;
        m1_req    = 1'b0;
        arm_ack   = 1'b0;
        arm_err   = 1'b0;
        arm_rdata = 32'd0;
        cycle();
        cycle();
        check("reset_outputs_dut8", 32'(any_out(0)), 32'd0);
        check("reset_outputs_dut4", 32'(any_out(1)), 32'd0);
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m0_addr = 32'hEA731337; m0_wdata = 32'h01020304; m0_wstrb = 4'h3; m0_wr = 1'b0;
        m1_addr = 32'hDEADBEEF; m1_wdata = 32'h0BADF00D; m1_wstrb = 4'hF; m1_wr = 1'b1;

        //  m0 m1 ack err rdata           req a0 a1 e0 e1 r0             r1             addr
        add(H, L, L, L, 32'h0,            H, L, L, L, L, 32'h0,        32'h0,        32'hEA731337);
        add(H, L, L, L, 32'h0,            H, L, L, L, L, 32'h0,        32'h0,        32'hEA731337);
        add(H, L, L, L, 32'h0,            H, L, L, L, L, 32'h0,        32'h0,        32'hEA731337);
        add(H, L, H, L, 32'h12345678,     L, H, L, L, L, 32'h12345678, 32'h0,        32'hEA731337);
        add(L, L, H, L, 32'hFFFFFFFF,     L, L, L, L, L, 32'h0,        32'h0,        32'hEA731337);
        add(L, L, H, H, 32'hFFFFFFFF,     L, L, L, L, L, 32'h0,        32'h0,        32'hEA731337);
        add(H, H, L, L, 32'h0,            H, L, L, L, L, 32'h0,        32'h0,        32'hDEADBEEF);
        add(H, H, H, H, 32'hA5A5A5A5,     L, L, H, L, H, 32'h0,        32'hA5A5A5A5, 32'hDEADBEEF);
        add(H, H, L, L, 32'h0,            L, L, L, L, L, 32'h0,        32'h0,        32'hDEADBEEF);
        add(H, H, L, L, 32'h0,            H, L, L, L, L, 32'h0,        32'h0,        32'hEA731337);
        add(H, H, H, L, 32'h0000FFFF,     L, H, L, L, L, 32'h0000FFFF, 32'h0,        32'hEA731337);
        add(L, H, L, L, 32'h0,            L, L, L, L, L, 32'h0,        32'h0,        32'hEA731337);
        add(L, H, L, L, 32'h0,            H, L, L, L, L, 32'h0,        32'h0,        32'hDEADBEEF);
        add(L, H, H, L, 32'h11112222,     L, L, H, L, L, 32'h0,        32'h11112222, 32'hDEADBEEF);
        add(L, H, L, L, 32'h0,            L, L, L, L, L, 32'h0,        32'h0,        32'hDEADBEEF);
        add(L, H, L, L, 32'h0,            H, L, L, L, L, 32'h0,        32'h0,        32'hDEADBEEF);
        add(L, L, L, L, 32'h0,            H, L, L, L, L, 32'h0,        32'h0,        32'hDEADBEEF);
        add(L, L, H, L, 32'h33334444,     L, L, H, L, L, 32'h0,        32'h33334444, 32'hDEADBEEF);
        add(L, L, L, L, 32'h0,            L, L, L, L, L, 32'h0,        32'h0,        32'hDEADBEEF);

        // ---------------- table-driven vectors (TIMEOUT=8 instance) ----------
        @(negedge clk);
        do_reset();
        foreach (vecs[i]) begin
            m0_req = vecs[i].m0; m1_req = vecs[i].m1;
            arm_ack = vecs[i].ack; arm_err = vecs[i].err; arm_rdata = vecs[i].rd;
            cycle();
            n_tests++;
            if (areq[0] !== vecs[i].e_req || m0a[0] !== vecs[i].e_a0 || m1a[0] !== vecs[i].e_a1 ||
                m0e[0] !== vecs[i].e_e0 || m1e[0] !== vecs[i].e_e1 || m0r[0] !== vecs[i].e_r0 ||
                m1r[0] !== vecs[i].e_r1 || aaddr[0] !== vecs[i].e_addr) begin
                n_fail++;
                $display("FAIL vec%0d: got req=%b ack=%b%b err=%b%b r0=%h r1=%h addr=%h expected req=%b ack=%b%b err=%b%b r0=%h r1=%h addr=%h",
                         i, areq[0], m0a[0], m1a[0], m0e[0], m1e[0], m0r[0], m1r[0], aaddr[0],
                         vecs[i].e_req, vecs[i].e_a0, vecs[i].e_a1, vecs[i].e_e0, vecs[i].e_e1,
                         vecs[i].e_r0, vecs[i].e_r1, vecs[i].e_addr);
            end
        end

        // ---------------- contention: both held, 1-cycle target -------------
        begin
            int ng = 0;
            int low = 0;
            logic seen = 1'b0;
            logic prev = 1'b0;
            int order[4];
            do_reset();
            m0_req = 1'b1;
            m1_req = 1'b1;
            for (int c = 0; c < 60 && ng < 4; c++) begin
                cycle();
                if (m0a[0]) begin order[ng] = 0; ng++; end
                else if (m1a[0]) begin order[ng] = 1; ng++; end
                if (areq[0] && !prev) begin
                    if (seen) check("contention_gap", 32'(low), 32'd2);
                    seen = 1'b1;
                end
                low  = areq[0] ? 0 : low + 1;
                prev = areq[0];
                arm_ack = areq[0];
            end
            check("contention_grants", 32'(ng), 32'd4);
            if (ng == 4) begin
                check("contention_order0", 32'(order[0]), 32'd0);
                check("contention_order1", 32'(order[1]), 32'd1);
                check("contention_order2", 32'(order[2]), 32'd0);
                check("contention_order3", 32'(order[3]), 32'd1);
            end
            m0_req = 1'b0;
            m1_req = 1'b0;
            arm_ack = 1'b0;
        end

        // ---------------- timeout: m1 write, target silent ------------------
        begin
            int hi0 = 0, hi1 = 0;
            logic d0 = 1'b0, d1 = 1'b0;
            logic [31:0] r0 = 32'hX, r1 = 32'hX;
            logic e0 = 1'b0, e1 = 1'b0, stray = 1'b0;
            do_reset();
            m1_req = 1'b1;
            for (int c = 0; c < 30 && !(d0 && d1); c++) begin
                cycle();
                if (m0a[0] || m0a[1]) stray = 1'b1;
                if (!d0) begin
                    if (c == 0) begin
                        check("timeout_arm_addr", aaddr[0], 32'hDEADBEEF);
                        check("timeout_arm_wdata", awdata[0], 32'h0BADF00D);
                        check("timeout_arm_wr", 32'(awr[0]), 32'd1);
                    end
                    if (areq[0]) hi0++;
                    if (m1a[0]) begin d0 = 1'b1; r0 = m1r[0]; e0 = m1e[0]; end
                end
                if (!d1) begin
                    if (areq[1]) hi1++;
                    if (m1a[1]) begin d1 = 1'b1; r1 = m1r[1]; e1 = m1e[1]; end
                end
                if (c == 1) m1_addr = 32'h00000000;
            end
            m1_addr = 32'hDEADBEEF;
            check("timeout8_acked", 32'(d0), 32'd1);
            check("timeout8_busy_cycles", 32'(hi0), 32'd8);
            check("timeout8_err", 32'(e0), 32'd1);
            check("timeout8_rdata", r0, 32'd0);
            check("timeout4_busy_cycles", 32'(hi1), 32'd4);
            check("timeout4_err", 32'(e1), 32'd1);
            check("timeout4_rdata", r1, 32'd0);
            check("timeout_no_m0_ack", 32'(stray), 32'd0);
            m1_req = 1'b0;
        end

        // ---------------- tie: ack on the 4th BUSY cycle with TIMEOUT=4 -----
        begin
            int acks = 0;
            do_reset();
            m0_req = 1'b1;
            cycle();
            m0_req = 1'b0;
            check("tie_granted", 32'(areq[1]), 32'd1);
            for (int k = 2; k <= 4; k++) begin
                cycle();
                if (m0a[1] || m1a[1]) acks++;
            end
            arm_ack = 1'b1; arm_err = 1'b1; arm_rdata = 32'hCAFEF00D;
            cycle();
            arm_ack = 1'b0; arm_err = 1'b0; arm_rdata = 32'd0;
            check("tie_ack", 32'(m0a[1]), 32'd1);
            check("tie_err", 32'(m0e[1]), 32'd1);
            check("tie_rdata", m0r[1], 32'hCAFEF00D);
            check("tie_rdata_dut8", m0r[0], 32'hCAFEF00D);
            if (m0a[1] || m1a[1]) acks++;
            for (int k = 0; k < 6; k++) begin
                cycle();
                if (m0a[1] || m1a[1]) acks++;
                if (k == 0) check("tie_rdata_cleared", m0r[1], 32'd0);
            end
            check("tie_single_ack", 32'(acks), 32'd1);
        end

        // ---------------- reset asserted mid-BUSY ---------------------------
        begin
            int acks = 0;
            do_reset();
            m0_req = 1'b1;
            cycle();
            check("midrst_busy", 32'(areq[0]), 32'd1);
            #2;
            resetn = 1'b0;
            #1;
            check("midrst_outputs_zero", 32'(any_out(0) | any_out(1)), 32'd0);
            for (int k = 0; k < 2; k++) begin
                cycle();
                if (m0a[0] || m1a[0]) acks++;
            end
            resetn = 1'b1;
            cycle();
            if (m0a[0] || m1a[0]) acks++;
            check("midrst_no_ack", 32'(acks), 32'd0);
            check("midrst_regrant", 32'(areq[0]), 32'd1);
            check("midrst_regrant_addr", aaddr[0], 32'hEA731337);
            arm_ack = 1'b1; arm_rdata = 32'h55AA55AA;
            cycle();
            arm_ack = 1'b0; arm_rdata = 32'd0;
            m0_req = 1'b0;
            check("midrst_final_ack", 32'(m0a[0]), 32'd1);
            check("midrst_final_rdata", m0r[0], 32'h55AA55AA);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arm_arb.md
ARM_ARB -- requirements
Module: arm_arb

Interface
REQ-001 The module SHALL take parameter TIMEOUT, default 255, meaning the maximum cycles in BUSY before abort (legal range 1..65535).
REQ-002 Port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 Port resetn, input, 1, meaning reset; it is asynchronous and active-low.
REQ-004 Ports m0_req / m1_req, input, 1 each, meaning the requester holds req high until it sees its ack.
REQ-005 Ports m0_addr / m1_addr, input, 32 each, meaning the request address.
REQ-006 Ports m0_wdata / m1_wdata, input, 32 each, meaning the write data.
REQ-007 Ports m0_wstrb / m1_wstrb, input, 4 each, meaning the write byte strobes.
REQ-008 Ports m0_wr / m1_wr, input, 1 each, meaning 1=write, 0=read.
REQ-009 Ports m0_ack / m1_ack, output, 1 each, meaning a one-cycle completion pulse.
REQ-010 Ports m0_rdata / m1_rdata, output, 32 each, meaning read data, valid only in the ack cycle.
REQ-011 Ports m0_err / m1_err, output, 1 each, meaning an error flag, valid only in the ack cycle.
REQ-012 Ports arm_addr, arm_wdata, arm_wstrb, arm_wr, output, 32/32/4/1, meaning the registered copy of the granted request.
REQ-013 Port arm_req, output, 1, meaning the request to the shared target.
REQ-014 Ports arm_ack, input, 1, and arm_err, input, 1, meaning target completion and target error.
REQ-015 Port arm_rdata, input, 32, meaning target read data, sampled when arm_ack=1.

Function
REQ-016 The FSM SHALL have exactly three states:
- IDLE: accept requests.
- BUSY: target transfer in flight.
- DONE: one-cycle turnaround; all m*_req ignored.

REQ-017 In IDLE, with any m*_req=1, the block SHALL:
- grant one requester;
- latch its addr/wdata/wstrb/wr into the arm_* registers;
- set arm_req=1 and enter BUSY at the same edge.

REQ-018 Arbitration SHALL be round-robin:
- on simultaneous requests, the requester not granted most recently wins;
- after reset, m0 has priority.

REQ-019 A single pending request SHALL be granted regardless of round-robin priority.
REQ-020 In BUSY, arm_* outputs SHALL stay stable; deassertion or change of the granted m*_req or its fields SHALL be ignored.
REQ-021 In BUSY, when arm_ack=1 is sampled, the block SHALL at that edge:
- set arm_req=0;
- pulse the granted m*_ack=1 for exactly one cycle, with m*_rdata=arm_rdata and m*_err=arm_err;
- enter DONE.

REQ-022 The non-granted requester's ack SHALL stay 0 and its request SHALL remain pending untouched.
REQ-023 DONE SHALL always return to IDLE on the next edge; min request-to-request spacing on arm_req is therefore 2 idle cycles.
REQ-024 Latency from m*_req sampled in IDLE to the m*_ack pulse SHALL be (target ack latency + 1) cycles.
REQ-025 A 16-bit timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle without arm_ack.
REQ-026 When the counter reaches TIMEOUT, the block SHALL at that edge:
- set arm_req=0;
- pulse the granted m*_ack with m*_err=1 and m*_rdata=0;
- enter DONE.

REQ-027 If arm_ack=1 is sampled in the same cycle the counter reaches TIMEOUT, the target response SHALL win: data and arm_err are passed through, no timeout error.
REQ-028 arm_ack sampled while in IDLE or DONE (stray ack) SHALL be ignored, with no m*_ack generated.
REQ-029 Outside the ack cycle, m*_rdata and m*_err SHALL be 0.

Reset
REQ-030 On resetn=0, asynchronously and regardless of state, the block SHALL:
- enter IDLE;
- clear all outputs: arm_req, arm_wr, arm_addr, arm_wdata, arm_wstrb, m*_ack, m*_err, m*_rdata;
- clear the timeout counter;
- set round-robin priority to m0.

REQ-031 Reset asserted mid-BUSY SHALL abort the transfer with no ack to any requester; after release, a held m*_req SHALL be re-granted from IDLE.

Verification
REQ-032 Single read: m0_req=1, addr=32'hEA731337, wr=0; target acks 3 cycles after arm_req with rdata=32'h12345678 -> arm_addr=32'hEA731337, m0_ack one cycle, m0_rdata=32'h12345678, m0_err=0.
REQ-033 Contention: m0_req and m1_req rise together, both held -> grant order m0, m1, m0, m1; each arm_req separated by ≥2 low cycles.
REQ-034 Timeout: TIMEOUT=8, m1 write addr=32'hDEADBEEF, target never acks -> arm_req drops after 8 BUSY cycles, m1_ack=1, m1_err=1, m1_rdata=0.
REQ-035 Tie: TIMEOUT=4, arm_ack=1 on the 4th BUSY cycle with arm_err=1 -> exactly one m*_ack, err=1 from the target, data passed through.
REQ-036 Disturbance: stray arm_ack in IDLE -> no m*_ack; resetn low mid-BUSY -> all outputs 0 immediately, no ack, clean re-grant after release.
